// File: rtl/tl_ctrl_timed.sv
// Two-road traffic-light controller with tick-timed phases, all-red clearance,
// night flash mode, and an optional pedestrian request (enabled by `define TL_PED_EN).
module tl_ctrl_timed #(
    parameter int CNT_W       = 8,
    parameter int GREEN_A     = 8,
    parameter int GREEN_B     = 6,
    parameter int YELLOW      = 2,
    parameter int ALL_RED     = 1,
    parameter int MIN_GREEN_A = 4,
    parameter int FLASH_HALF  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       flash_req,
    input  logic       ped_req,
    output logic [5:0] TL,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        A_GREEN   = 3'd1,
        A_YELLOW  = 3'd2,
        ALL_RED_1 = 3'd3,
        B_GREEN   = 3'd4,
        B_YELLOW  = 3'd5,
        ALL_RED_2 = 3'd6,
        FLASH     = 3'd7
    } state_e;

    // A zero duration behaves as a single tick.
    localparam int GA_EFF = (GREEN_A     > 0) ? GREEN_A     : 1;
    localparam int GB_EFF = (GREEN_B     > 0) ? GREEN_B     : 1;
    localparam int YL_EFF = (YELLOW      > 0) ? YELLOW      : 1;
    localparam int AR_EFF = (ALL_RED     > 0) ? ALL_RED     : 1;
    localparam int MG_EFF = (MIN_GREEN_A > 0) ? MIN_GREEN_A : 1;
    localparam int FH_EFF = (FLASH_HALF  > 0) ? FLASH_HALF  : 1;

    localparam logic [CNT_W-1:0] GA_LAST = CNT_W'(GA_EFF - 1);
    localparam logic [CNT_W-1:0] GB_LAST = CNT_W'(GB_EFF - 1);
    localparam logic [CNT_W-1:0] YL_LAST = CNT_W'(YL_EFF - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(AR_EFF - 1);
    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MG_EFF - 1);
    localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(FH_EFF - 1);

    function automatic logic [5:0] lamps(input state_e s, input logic flash_on);
        case (s)
            A_GREEN:   lamps = 6'b100001;
            A_YELLOW:  lamps = 6'b010001;
            ALL_RED_1: lamps = 6'b001001;
            B_GREEN:   lamps = 6'b001100;
            B_YELLOW:  lamps = 6'b001010;
            ALL_RED_2: lamps = 6'b001001;
            FLASH:     lamps = flash_on ? 6'b010010 : 6'b000000;
            default:   lamps = 6'b000000;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_c;
    logic             flash_q, flash_d;
    logic             done_c;
    logic             walk_q, walk_d;
    logic [5:0]       tl_q;
    logic [2:0]       phase_q;

`ifdef TL_PED_EN
    logic ped_q, ped_d, enter_b;
`endif

    always_comb begin
        case (state_q)
            A_GREEN:              last_c = GA_LAST;
            B_GREEN:              last_c = GB_LAST;
            A_YELLOW, B_YELLOW:   last_c = YL_LAST;
            ALL_RED_1, ALL_RED_2: last_c = AR_LAST;
            FLASH:                last_c = FH_LAST;
            default:              last_c = '0;
        endcase
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        done_c  = (cnt_q == last_c);
`ifdef TL_PED_EN
        if (state_q == A_GREEN && ped_q && cnt_q >= MG_LAST) done_c = 1'b1;
`endif
        if (state_q == IDLE) begin
            state_d = A_GREEN;
            cnt_d   = '0;
        end else if (tick) begin
            if (!done_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                case (state_q)
                    A_GREEN:  state_d = A_YELLOW;
                    A_YELLOW: state_d = ALL_RED_1;
                    B_GREEN:  state_d = B_YELLOW;
                    B_YELLOW: state_d = ALL_RED_2;
                    // All-red ends are the only safe points to enter flash mode.
                    ALL_RED_1, ALL_RED_2: begin
                        if (flash_req) begin
                            state_d = FLASH;
                            flash_d = 1'b1;
                        end else begin
                            state_d = (state_q == ALL_RED_1) ? B_GREEN : A_GREEN;
                        end
                    end
                    FLASH: begin
                        if (!flash_q && !flash_req) state_d = ALL_RED_2;
                        else                        flash_d = !flash_q;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

`ifdef TL_PED_EN
    // Walk is granted for a whole B_GREEN when a request was pending at its entry.
    always_comb begin
        enter_b = (state_d == B_GREEN) && (state_q != B_GREEN);
        ped_d   = ped_req || (ped_q && !enter_b);
        walk_d  = (state_d == B_GREEN) && (enter_b ? ped_q : walk_q);
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign walk_d     = 1'b0;
`endif

    // NOTE: reset is synchronous, so it only appears inside the clocked block, never in the sensitivity list.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flash_q <= 1'b0;
            walk_q  <= 1'b0;
            tl_q    <= 6'b000000;
            phase_q <= 3'd0;
`ifdef TL_PED_EN
            ped_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
            walk_q  <= walk_d;
            // Outputs are registered decodes of the next state, so they track state_q exactly.
            tl_q    <= lamps(state_d, flash_d);
            phase_q <= state_d;
`ifdef TL_PED_EN
            ped_q   <= ped_d;
`endif
        end
    end

    assign TL    = tl_q;
    assign walk  = walk_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_tl_ctrl_timed.sv
// Self-checking bench for tl_ctrl_timed: a vector table for reset and the normal
// cycle, then hand sequences for slow tick, pedestrian, flash and mid-run reset.
module tb_tl_ctrl_timed;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       flash_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [5:0] TL;
    logic       walk;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;

    tl_ctrl_timed dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .flash_req (flash_req),
        .ped_req   (ped_req),
        .TL        (TL),
        .walk      (walk),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] L_OFF = 6'b000000;
    localparam logic [5:0] L_AG  = 6'b100001;
    localparam logic [5:0] L_AY  = 6'b010001;
    localparam logic [5:0] L_RED = 6'b001001;
    localparam logic [5:0] L_BG  = 6'b001100;
    localparam logic [5:0] L_BY  = 6'b001010;
    localparam logic [5:0] L_FL  = 6'b010010;

`ifdef TL_PED_EN
    localparam int   PED_AG_REST = 3;
    localparam logic PED_WALK    = 1'b1;
`else
    localparam int   PED_AG_REST = 7;
    localparam logic PED_WALK    = 1'b0;
`endif

    typedef struct {
        logic       rst_n;
        logic       tk;
        logic       fl;
        logic       pd;
        logic [2:0] ph;
        logic [5:0] tl;
        logic       wk;
    } vec_t;

    vec_t vecs[$];

    int         slow_dur[6] = '{8, 2, 1, 6, 2, 1};
    logic [2:0] slow_ph[6]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [5:0] slow_tl[6]  = '{L_AG, L_AY, L_RED, L_BG, L_BY, L_RED};

    function automatic void add(input int n, input logic r, input logic t, input logic f,
                                input logic p, input logic [2:0] ph, input logic [5:0] tl,
                                input logic wk);
        vec_t v;
        v.rst_n = r; v.tk = t; v.fl = f; v.pd = p; v.ph = ph; v.tl = tl; v.wk = wk;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_obs(input string tag, input logic [2:0] ph, input logic [5:0] tl,
                             input logic wk);
        check({tag, " phase"}, int'(phase), int'(ph));
        check({tag, " TL"},    int'(TL),    int'(tl));
        check({tag, " walk"},  int'(walk),  int'(wk));
    endtask

    // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic r, input logic t, input logic f, input logic p);
        reset = r; tick = t; flash_req = f; ped_req = p;
        @(posedge clk);
        #1;
    endtask

    task automatic run_expect(input string tag, input int n, input logic [2:0] ph,
                              input logic [5:0] tl, input logic wk, input logic t,
                              input logic f, input logic p_first);
        for (int i = 0; i < n; i++) begin
            step(1'b1, t, f, (i == 0) ? p_first : 1'b0);
            check_obs($sformatf("%s[%0d]", tag, i), ph, tl, wk);
        end
    endtask

    initial begin
        // Reset held 3 edges, then one full 20-cycle period and the start of the next.
        add(3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, L_OFF, 1'b0);
        add(8, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, L_AG,  1'b0);
        add(2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, L_AY,  1'b0);
        add(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, L_RED, 1'b0);
        add(6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, L_BG,  1'b0);
        add(2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, L_BY,  1'b0);
        add(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, L_RED, 1'b0);
        add(8, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, L_AG,  1'b0);
        add(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, L_AY,  1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].tk, vecs[i].fl, vecs[i].pd);
            check_obs($sformatf("vec%0d", i), vecs[i].ph, vecs[i].tl, vecs[i].wk);
        end

        // Tick every 4th cycle: each phase lasts 4x; IDLE still leaves without a tick.
        begin
            int j;
            j = 0;
            step(1'b0, 1'b1, 1'b0, 1'b0);
            for (int p = 0; p < 6; p++) begin
                for (int k = 0; k < 4 * slow_dur[p]; k++) begin
                    step(1'b1, (j != 0 && j % 4 == 0), 1'b0, 1'b0);
                    check_obs($sformatf("slow%0d", j), slow_ph[p], slow_tl[p], 1'b0);
                    j++;
                end
            end
            step(1'b1, (j % 4 == 0), 1'b0, 1'b0);
            check_obs("slow_wrap", 3'd1, L_AG, 1'b0);
        end

        // Pedestrian pulse on the first tick of A_GREEN.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_obs("ped_start", 3'd1, L_AG, 1'b0);
        run_expect("ped_ag",  PED_AG_REST, 3'd1, L_AG,  1'b0,     1'b1, 1'b0, 1'b1);
        run_expect("ped_ay",  2,           3'd2, L_AY,  1'b0,     1'b1, 1'b0, 1'b0);
        run_expect("ped_r1",  1,           3'd3, L_RED, 1'b0,     1'b1, 1'b0, 1'b0);
        run_expect("ped_bg",  6,           3'd4, L_BG,  PED_WALK, 1'b1, 1'b0, 1'b0);
        run_expect("ped_by",  2,           3'd5, L_BY,  1'b0,     1'b1, 1'b0, 1'b0);
        run_expect("ped_r2",  1,           3'd6, L_RED, 1'b0,     1'b1, 1'b0, 1'b0);
        run_expect("ped_ag2", 8,           3'd1, L_AG,  1'b0,     1'b1, 1'b0, 1'b0);
        run_expect("ped_ay2", 1,           3'd2, L_AY,  1'b0,     1'b1, 1'b0, 1'b0);

        // Flash request raised in A_GREEN, dropped during an on half-period.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_obs("fl_start", 3'd1, L_AG, 1'b0);
        run_expect("fl_ag",   7, 3'd1, L_AG,  1'b0, 1'b1, 1'b1, 1'b0);
        run_expect("fl_ay",   2, 3'd2, L_AY,  1'b0, 1'b1, 1'b1, 1'b0);
        run_expect("fl_r1",   1, 3'd3, L_RED, 1'b0, 1'b1, 1'b1, 1'b0);
        run_expect("fl_on0",  2, 3'd7, L_FL,  1'b0, 1'b1, 1'b1, 1'b0);
        run_expect("fl_off0", 2, 3'd7, L_OFF, 1'b0, 1'b1, 1'b1, 1'b0);
        run_expect("fl_on1",  2, 3'd7, L_FL,  1'b0, 1'b1, 1'b1, 1'b0);
        run_expect("fl_off1", 2, 3'd7, L_OFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_expect("fl_r2",   1, 3'd6, L_RED, 1'b0, 1'b1, 1'b0, 1'b0);
        run_expect("fl_ag2",  1, 3'd1, L_AG,  1'b0, 1'b1, 1'b0, 1'b0);

        // Reset for one edge mid B_GREEN with a request pending; full A_GREEN follows.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        run_expect("rst_ag", 7, 3'd1, L_AG,  1'b0, 1'b1, 1'b0, 1'b0);
        run_expect("rst_ay", 2, 3'd2, L_AY,  1'b0, 1'b1, 1'b0, 1'b0);
        run_expect("rst_r1", 1, 3'd3, L_RED, 1'b0, 1'b1, 1'b0, 1'b0);
        run_expect("rst_bg", 2, 3'd4, L_BG,  1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_obs("rst_mid", 3'd0, L_OFF, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_obs("rst_restart", 3'd1, L_AG, 1'b0);
        run_expect("rst_ag2", 7, 3'd1, L_AG, 1'b0, 1'b1, 1'b0, 1'b0);
        run_expect("rst_ay2", 1, 3'd2, L_AY, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
